// File: rtl/quant_pkg.sv
// Shared constants and types for the runtime-QP quantization stage.
// The MF table pairs with a shift of SHIFT_BASE + qp/6 to form the per-block quant step.
package quant_pkg;

  localparam int unsigned SHIFT_BASE = 19;
  localparam int unsigned QP_MAX     = 51;
  localparam int unsigned PROD_W     = 33;

  localparam logic [14:0] MF_TABLE [6] = '{
    15'd26214, 15'd23302, 15'd20560, 15'd18396, 15'd16384, 15'd14564
  };

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} qstate_t;

  typedef logic [5:0]               idx_t;
  typedef logic signed [15:0]       level_t;
  typedef logic signed [PROD_W-1:0] prod_t;

  // f_idx is always qp % 6; out-of-range codes fall back to entry 0.
  function automatic logic [14:0] mf_lookup(input logic [2:0] f_idx);
    return (f_idx < 3'd6) ? MF_TABLE[f_idx] : MF_TABLE[0];
  endfunction

endpackage

// File: rtl/quant_round_shift.sv
// Stage-2 arithmetic: arithmetic right shift of the product with rounding half away from zero.
// Purely combinational; the result is truncated to WIDTH.
module quant_round_shift
  import quant_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  prod_t                   prod,
  input  logic [4:0]              shift,
  output logic signed [WIDTH-1:0] q
);

  logic [PROD_W-1:0] half;
  logic [PROD_W-1:0] low_mask;
  prod_t             shifted;
  logic              round_bit;
  logic              sticky;
  logic              inc;

  always_comb begin
    half      = PROD_W'(1) << (shift - 5'd1);
    low_mask  = half - PROD_W'(1);
    shifted   = prod >>> shift;
    round_bit = |(prod & half);
    sticky    = |(prod & low_mask);
    // Floor already moves negatives away from zero; only an above-half remainder rounds back up.
    inc       = prod[PROD_W-1] ? (round_bit & sticky) : round_bit;
    q         = WIDTH'(shifted + {{(PROD_W-1){1'b0}}, inc});
  end

endmodule

// File: rtl/quant_stage_ctrl.sv
// Block-level quantizer controller: latches QP per 8x8 block and streams 64 coefficients
// through a 2-stage multiply / round-shift pipeline with valid/ready on both sides.
module quant_stage_ctrl #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned NCOEF  = 64,
  parameter int unsigned QP_MAX = quant_pkg::QP_MAX
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    clr,
  input  logic [5:0]              qp,
  input  logic                    s_valid,
  input  logic signed [WIDTH-1:0] s_data,
  output logic                    s_ready,
  output logic                    m_valid,
  output logic signed [WIDTH-1:0] m_data,
  output quant_pkg::idx_t         m_idx,
  output logic                    m_last,
  input  logic                    m_ready,
  output logic                    busy,
  output logic                    done
);

  localparam quant_pkg::idx_t LastIdx = quant_pkg::idx_t'(NCOEF - 1);
  localparam int unsigned     PW      = quant_pkg::PROD_W;

  quant_pkg::qstate_t state_q, state_d;
  logic [14:0]        mf_q;
  logic [4:0]         shift_q;
  quant_pkg::idx_t    in_cnt_q;
  logic               v1_q;
  quant_pkg::prod_t   prod1_q;
  quant_pkg::idx_t    idx1_q;

  logic                    pe;
  logic                    in_hs;
  logic                    out_hs;
  logic                    latch;
  logic                    done_d;
  logic [5:0]              qp_sat;
  logic [2:0]              f_idx;
  logic [4:0]              shift_new;
  quant_pkg::prod_t        prod;
  logic signed [WIDTH-1:0] q_rnd;

  always_comb begin
    pe        = !(m_valid && !m_ready);
    s_ready   = (state_q == quant_pkg::RUN) && pe;
    in_hs     = s_valid && s_ready;
    out_hs    = m_valid && m_ready;
    busy      = (state_q != quant_pkg::IDLE);
    qp_sat    = (qp > 6'(QP_MAX)) ? 6'(QP_MAX) : qp;
    f_idx     = 3'(qp_sat % 6'd6);
    shift_new = 5'(quant_pkg::SHIFT_BASE) + 5'(qp_sat / 6'd6);
    prod      = quant_pkg::prod_t'(s_data) * $signed({{(PW-15){1'b0}}, mf_q});
  end

  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    latch   = 1'b0;
    if (clr) begin
      state_d = quant_pkg::IDLE;
    end else begin
      unique case (state_q)
        quant_pkg::IDLE: begin
          if (start) begin
            state_d = quant_pkg::RUN;
            latch   = 1'b1;
          end
        end
        quant_pkg::RUN: begin
          if (in_hs && (in_cnt_q == LastIdx)) state_d = quant_pkg::DRAIN;
        end
        quant_pkg::DRAIN: begin
          if (out_hs && m_last) begin
            state_d = quant_pkg::IDLE;
            done_d  = 1'b1;
          end
        end
        default: state_d = quant_pkg::IDLE;
      endcase
    end
  end

  quant_round_shift #(
    .WIDTH (WIDTH)
  ) u_round_shift (
    .prod  (prod1_q),
    .shift (shift_q),
    .q     (q_rnd)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= quant_pkg::IDLE;
      mf_q     <= '0;
      shift_q  <= '0;
      in_cnt_q <= '0;
      v1_q     <= 1'b0;
      prod1_q  <= '0;
      idx1_q   <= '0;
      m_valid  <= 1'b0;
      m_data   <= '0;
      m_idx    <= '0;
      m_last   <= 1'b0;
      done     <= 1'b0;
    end else begin
      state_q <= state_d;
      done    <= done_d;
      if (latch) begin
        mf_q    <= quant_pkg::mf_lookup(f_idx);
        shift_q <= shift_new;
      end
      if (clr) begin
        in_cnt_q <= '0;
        v1_q     <= 1'b0;
        m_valid  <= 1'b0;
        m_last   <= 1'b0;
      end else begin
        if (in_hs) in_cnt_q <= (in_cnt_q == LastIdx) ? '0 : in_cnt_q + 1'b1;
        // Single enable for both stages: an output stall freezes the whole pipe.
        if (pe) begin
          v1_q    <= in_hs;
          prod1_q <= prod;
          idx1_q  <= in_cnt_q;
          m_valid <= v1_q;
          m_data  <= q_rnd;
          m_idx   <= idx1_q;
          m_last  <= v1_q && (idx1_q == LastIdx);
        end
      end
    end
  end

endmodule

// File: tb/tb_quant_stage_ctrl.sv
// Self-checking bench for quant_stage_ctrl: scoreboard of expected levels filled at input
// handshake, drained by an output monitor that also checks hold-under-stall.
module tb_quant_stage_ctrl;

  logic               clk, rst, start, clr;
  logic [5:0]         qp;
  logic               s_valid;
  logic signed [15:0] s_data;
  logic               s_ready, m_valid;
  logic signed [15:0] m_data;
  logic [5:0]         m_idx;
  logic               m_last, m_ready, busy, done;

  typedef struct packed {
    logic signed [15:0] data;
    logic [5:0]         idx;
    logic               last;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   start_cyc = 0;
  int   last_cyc = 0;
  int   out_count = 0;
  int   done_count = 0;
  bit   rand_ready = 0;

  logic signed [15:0] coef [64];
  logic signed [15:0] coef_keep [64];
  logic signed [15:0] fix_val [64];
  bit                 fix_en [64];

  quant_stage_ctrl #(
    .WIDTH  (16),
    .NCOEF  (64),
    .QP_MAX (51)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .clr     (clr),
    .qp      (qp),
    .s_valid (s_valid),
    .s_data  (s_data),
    .s_ready (s_ready),
    .m_valid (m_valid),
    .m_data  (m_data),
    .m_idx   (m_idx),
    .m_last  (m_last),
    .m_ready (m_ready),
    .busy    (busy),
    .done    (done)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  initial begin
    m_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      m_ready = rand_ready ? ($urandom_range(0, 99) < 30) : 1'b1;
    end
  end

  function automatic int mf_tb(input int f);
    case (f)
      0: return 26214;
      1: return 23302;
      2: return 20560;
      3: return 18396;
      4: return 16384;
      default: return 14564;
    endcase
  endfunction

  // Magnitude rounded half-up, then sign restored: equals round-half-away-from-zero.
  function automatic logic signed [15:0] model(input logic signed [15:0] x, input int qv);
    int     qe, sh;
    longint a, r;
    qe = (qv > 51) ? 51 : qv;
    sh = 19 + qe / 6;
    a  = (x < 0) ? -longint'(x) : longint'(x);
    a  = a * longint'(mf_tb(qe % 6));
    r  = (a + (longint'(1) << (sh - 1))) >> sh;
    if (x < 0) r = -r;
    return 16'(r);
  endfunction

  // Output monitor / scoreboard consumer.
  initial begin
    bit                 prev_stall, prev_clr, prev_last;
    logic signed [15:0] prev_data;
    logic [5:0]         prev_idx;
    exp_t               e;
    prev_stall = 0;
    prev_clr   = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 0;
      end else begin
        if (prev_stall && !prev_clr) begin
          checks++;
          if (m_valid !== 1'b1 || m_data !== prev_data || m_idx !== prev_idx ||
              m_last !== prev_last) begin
            errors++;
            $display("FAIL stall_hold: got v=%0b d=%0d i=%0d l=%0b, expected v=1 d=%0d i=%0d l=%0b",
                     m_valid, m_data, m_idx, m_last, prev_data, prev_idx, prev_last);
          end
        end
        if (m_valid && m_ready) begin
          checks++;
          if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_output: got d=%0d i=%0d, expected no beat", m_data, m_idx);
          end else begin
            e = sb_q.pop_front();
            if (m_data !== e.data || m_idx !== e.idx || m_last !== e.last) begin
              errors++;
              $display("FAIL output_beat: got d=%0d i=%0d l=%0b, expected d=%0d i=%0d l=%0b",
                       m_data, m_idx, m_last, e.data, e.idx, e.last);
            end
          end
          out_count++;
          if (m_last) last_cyc = cyc;
        end
        if (done) done_count++;
        prev_stall = m_valid && !m_ready;
        prev_data  = m_data;
        prev_idx   = m_idx;
        prev_last  = m_last;
      end
      prev_clr = clr;
    end
  end

  task automatic fill_random();
    for (int i = 0; i < 64; i++) begin
      fix_en[i] = 0;
      coef[i]   = 16'($urandom);
    end
  endtask

  // Starts a block and feeds n coefficients; start is re-pulsed at input poke_at (must be ignored).
  task automatic run_block(input int q, input int n, input int poke_at);
    int   i, guard;
    bit   first;
    exp_t e;
    start     = 1;
    qp        = 6'(q);
    start_cyc = cyc;
    @(posedge clk);
    #1;
    start = 0;
    qp    = 6'($urandom_range(0, 63));
    i     = 0;
    guard = 0;
    first = 1;
    while (i < n && guard < 3000) begin
      s_valid = 1;
      s_data  = coef[i];
      start   = (i == poke_at);
      @(negedge clk);
      if (first) begin
        checks++;
        if (busy !== 1'b1 || s_ready !== 1'b1) begin
          errors++;
          $display("FAIL first_cycle: got busy=%0b s_ready=%0b, expected 1 1", busy, s_ready);
        end
        first = 0;
      end
      if (s_ready) begin
        e.data = fix_en[i] ? fix_val[i] : model(coef[i], q);
        e.idx  = 6'(i);
        e.last = (i == 63);
        sb_q.push_back(e);
        i++;
      end
      @(posedge clk);
      #1;
      guard++;
    end
    s_valid = 0;
    start   = 0;
    checks++;
    if (i != n) begin
      errors++;
      $display("FAIL input_timeout: got %0d inputs, expected %0d", i, n);
    end
  endtask

  task automatic wait_done(input int bound);
    bit seen;
    seen = 0;
    for (int k = 0; k < bound && !seen; k++) begin
      @(negedge clk);
      if (done === 1'b1) seen = 1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL done_timeout: got no done, expected done within %0d cycles", bound);
    end
  endtask

  task automatic check_drained(input string name, input int exp_outs);
    checks++;
    if (sb_q.size() != 0 || out_count != exp_outs) begin
      errors++;
      $display("FAIL %s: got pending=%0d outs=%0d, expected pending=0 outs=%0d",
               name, sb_q.size(), out_count, exp_outs);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({s_ready, m_valid, m_data, m_idx, m_last, busy, done} !== '0) begin
      errors++;
      $display("FAIL reset_hold: got rdy=%0b v=%0b d=%0d i=%0d l=%0b busy=%0b done=%0b, expected all 0",
               s_ready, m_valid, m_data, m_idx, m_last, busy, done);
    end
    @(posedge clk);
    #1;
    rst = 0;
    repeat (2) @(negedge clk);
    checks++;
    if ({s_ready, m_valid, m_data, m_idx, m_last, busy, done} !== '0) begin
      errors++;
      $display("FAIL reset_idle: got rdy=%0b v=%0b d=%0d i=%0d l=%0b busy=%0b done=%0b, expected all 0",
               s_ready, m_valid, m_data, m_idx, m_last, busy, done);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_directed();
    out_count = 0;
    fill_random();
    coef[0] = 512;  fix_en[0] = 1; fix_val[0] = 1;
    coef[1] = 256;  fix_en[1] = 1; fix_val[1] = 1;
    coef[2] = -256; fix_en[2] = 1; fix_val[2] = -1;
    coef[3] = 255;  fix_en[3] = 1; fix_val[3] = 0;
    run_block(28, 64, -1);
    wait_done(400);
    fill_random();
    coef[0] = 1000;  fix_en[0] = 1; fix_val[0] = 50;
    coef[1] = -1000; fix_en[1] = 1; fix_val[1] = -50;
    run_block(0, 64, -1);
    wait_done(400);
    fill_random();
    coef[0] = 32767; fix_en[0] = 1; fix_val[0] = 4;
    run_block(60, 64, -1);
    wait_done(400);
    check_drained("directed_drain", 192);
  endtask

  task automatic test_full_block();
    int d0;
    @(posedge clk);
    #1;
    rand_ready = 0;
    out_count  = 0;
    fill_random();
    for (int i = 0; i < 64; i++) coef_keep[i] = coef[i];
    d0 = done_count;
    run_block(33, 64, -1);
    wait_done(200);
    checks++;
    if (cyc - start_cyc != 67) begin
      errors++;
      $display("FAIL done_cycle: got %0d, expected 67", cyc - start_cyc);
    end
    checks++;
    if (last_cyc - start_cyc != 66) begin
      errors++;
      $display("FAIL last_cycle: got %0d, expected 66", last_cyc - start_cyc);
    end
    check_drained("full_drain", 64);
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || done_count - d0 != 1) begin
      errors++;
      $display("FAIL done_pulse: got done=%0b pulses=%0d, expected done=0 pulses=1",
               done, done_count - d0);
    end
  endtask

  task automatic test_backpressure();
    @(posedge clk);
    #1;
    rand_ready = 1;
    out_count  = 0;
    for (int i = 0; i < 64; i++) begin
      coef[i]   = coef_keep[i];
      fix_en[i] = 0;
    end
    run_block(33, 64, -1);
    wait_done(3000);
    check_drained("stall_drain", 64);
    rand_ready = 0;
  endtask

  task automatic test_clr();
    int d0, leaks;
    @(posedge clk);
    #1;
    rand_ready = 0;
    fill_random();
    d0 = done_count;
    run_block(17, 20, -1);
    clr = 1;
    @(posedge clk);
    #1;
    clr = 0;
    sb_q.delete();
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || m_valid !== 1'b0) begin
      errors++;
      $display("FAIL clr_idle: got busy=%0b m_valid=%0b, expected 0 0", busy, m_valid);
    end
    leaks = 0;
    repeat (10) begin
      @(negedge clk);
      if (m_valid !== 1'b0 || busy !== 1'b0) leaks++;
    end
    checks++;
    if (leaks != 0 || done_count != d0) begin
      errors++;
      $display("FAIL clr_flush: got leaks=%0d dones=%0d, expected 0 0", leaks, done_count - d0);
    end
    @(posedge clk);
    #1;
    out_count = 0;
    fill_random();
    run_block(40, 64, 10);
    wait_done(400);
    check_drained("after_clr", 64);
  endtask

  task automatic test_back_to_back();
    int d0;
    @(posedge clk);
    #1;
    out_count = 0;
    d0        = done_count;
    fill_random();
    run_block(12, 64, -1);
    wait_done(400);
    fill_random();
    run_block(45, 64, 30);
    wait_done(400);
    check_drained("b2b_drain", 128);
    @(negedge clk);
    checks++;
    if (done_count - d0 != 2) begin
      errors++;
      $display("FAIL b2b_done: got %0d pulses, expected 2", done_count - d0);
    end
  endtask

  initial begin
    rst     = 1;
    start   = 0;
    clr     = 0;
    qp      = 0;
    s_valid = 0;
    s_data  = 0;
    test_reset();
    test_directed();
    test_full_block();
    test_backpressure();
    test_clr();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/quant_stage_ctrl.md
# quant_stage_ctrl

Runtime-QP quantization stage controller for the compression engine. It accepts one 8x8 block of transform coefficients (64 samples) per `start` over a valid/ready stream and sequences them through a 2-stage multiply/round/shift pipeline. It emits quantized levels downstream with index and last flags, then pulses `done`. It sits between the transform stage and the entropy/zigzag stage and replaces the compile-time-QP quantizer with a QP latched per block.

## Interface
- `WIDTH`, 16, coefficient and level width (signed)
- `NCOEF`, 64, coefficients per block
- `QP_MAX`, 51, largest legal QP; larger requests clamp to this value

- `clk`  in  1  sole clock, rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `start`  in  1  one-cycle pulse; begins a block, sampled only in IDLE
- `clr`  in  1  synchronous abort; flushes pipeline, returns to IDLE
- `qp`  in  6  quantization parameter, latched on accepted `start`
- `s_valid`  in  1  input coefficient valid
- `s_data`  in  WIDTH  signed input coefficient
- `s_ready`  out  1  controller accepts `s_data`
- `m_valid`  out  1  output level valid
- `m_data`  out  WIDTH  signed quantized level
- `m_idx`  out  6  coefficient index 0..63 of `m_data`
- `m_last`  out  1  high with index 63
- `m_ready`  in  1  downstream accepts output
- `busy`  out  1  state != IDLE
- `done`  out  1  one-cycle pulse after index 63 handshakes

## Operation
- FSM: IDLE -> RUN on `start`. RUN -> DRAIN when the 64th input handshakes. DRAIN -> IDLE when the `m_last` beat handshakes, with `done`=1 in that same transition cycle (registered, so visible the cycle after the handshake). `clr` from any state -> IDLE; it clears the counters and both pipeline valids. `clr` has priority over `start`.
- QP latch: `qp_r` = min(`qp`, `QP_MAX`). `f_idx` = `qp_r` % 6. `shift` = 19 + `qp_r`/6, range 19..27. Both are computed once at latch, not per sample.
- MF table, indexed by `f_idx`: 26214, 23302, 20560, 18396, 16384, 14564. Values are unsigned 15-bit.
- Stage 1: `prod` = `s_data` * MF, signed 33-bit, registered with its index.
- Stage 2: `q` = `prod` >>> `shift`, rounded half away from zero.
  - Positive: add `prod[shift-1]`.
  - Negative: add `prod[shift-1]` AND (OR of `prod[shift-2:0]`).
- The result always fits in WIDTH. The result is truncated to WIDTH with no saturation logic.
- Counters: `in_cnt` counts 0..63 on input handshakes. `m_idx` travels with data through the pipeline.
- Pipeline enable `pe` = !(`m_valid` && !`m_ready`). The whole pipe holds when the output stalls. There are no bubbles inserted and no data is lost.
- `s_ready` = (state==RUN) && `pe`.
- `start` while `busy` is ignored. `qp` changes mid-block have no effect.

## Timing
- Reset values: `s_ready`=0, `m_valid`=0, `m_data`=0, `m_idx`=0, `m_last`=0, `busy`=0, `done`=0. State is IDLE and `qp_r`=0.
- `start` at cycle 0 -> `busy`=1 and `s_ready`=1 from cycle 1.
- Latency: an input handshake at cycle t gives `m_valid` at t+2 when unstalled. Throughput is 1 coefficient/cycle.
- Full-rate block: the last input is at cycle 64 and `m_last` is at cycle 66. `done` is at cycle 67 if `m_ready` stays high.
- Backpressure: `m_data`, `m_idx` and `m_last` hold stable while `m_valid` && !`m_ready`.
- Back-to-back blocks: `start` is legal in the cycle `done` is high, since the state is already IDLE.
- Reset or `clr` mid-block discards all in-flight samples. No `done` is issued.

## Structure
- Package `quant_pkg`:
  - `MF_TABLE[6]`
  - `SHIFT_BASE`=19
  - `QP_MAX`
  - FSM enum `qstate_t` {IDLE, RUN, DRAIN}
  - level/index typedefs
- One sub-module: `quant_round_shift`. It is combinational and contains the stage-2 shift plus the away-from-zero rounding, taking `prod` and `shift`. The FSM, counters and pipeline registers stay in the top level.

## Test plan
- QP=28, inputs 512, 256, -256, 255: outputs 1, 1, -1, 0. This covers a tie at shift 23 and rounding toward zero below the half point.
- QP=0, input 1000: output 50. Input -1000: output -50.
- QP=60: clamps to 51 (f_idx 3, shift 27). Input 32767: output 4.
- Full block at full rate, `m_ready`=1:
  - 64 outputs, `m_idx` 0..63.
  - `m_last` only on index 63.
  - `done` exactly one cycle, at cycle 67.
- Random `m_ready` duty of about 30%: output sequence is identical to the unstalled run, and data is stable during stalls.
- `clr` asserted after 20 inputs: `busy`=0 next cycle, no further `m_valid`, no `done`. A following `start` block completes normally. `start` asserted while `busy` is ignored.
